// File: rtl/ikaopm_dac_deserializer_pkg.sv
// Shared constants and types for the OPM serial DAC receiver.
package ikaopm_dac_deserializer_pkg;

    localparam int FRAME_BITS = 13;
    localparam int MANT_W     = 10;
    localparam int EXP_W      = 3;
    localparam int PCM_W      = 16;
    localparam int CNT_W      = 5;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    // Layout of the 13 most recent bits: mantissa arrives first (LSB first),
    // so it ends up in the low bits of the shift register.
    typedef struct packed {
        logic [EXP_W-1:0]  exponent;
        logic [MANT_W-1:0] mantissa;
    } frame_word_t;

endpackage

// File: rtl/ikaopm_fp2pcm.sv
// Floating-point (YM3012 style) to 16-bit signed linear PCM conversion.
// Mantissa is offset binary; exponent 0 means silence, 1..7 scale by 2^(exp-1).
module ikaopm_fp2pcm
    import ikaopm_dac_deserializer_pkg::*;
(
    input  logic [MANT_W-1:0] i_MANTISSA,
    input  logic [EXP_W-1:0]  i_EXPONENT,
    output logic [PCM_W-1:0]  o_PCM
);

    logic signed [MANT_W-1:0] mant_signed;
    logic signed [PCM_W-1:0]  mant_ext;

    // Offset binary to two's complement, sign-extend, then scale; a shift of
    // at most 6 on a 10-bit value always fits in 16 bits.
    always_comb begin
        mant_signed = {~i_MANTISSA[MANT_W-1], i_MANTISSA[MANT_W-2:0]};
        mant_ext    = {{(PCM_W-MANT_W){mant_signed[MANT_W-1]}}, mant_signed};
        if (i_EXPONENT == '0) begin
            o_PCM = '0;
        end else begin
            o_PCM = mant_ext << (i_EXPONENT - EXP_W'(1));
        end
    end

endmodule

// File: rtl/ikaopm_dac_deserializer.sv
// Receive side of the OPM serial audio link: shifts in SO on bit-clock
// enables and closes a frame on each SH1/SH2 falling edge, producing a
// per-channel PCM word with a one-clock valid pulse.
module ikaopm_dac_deserializer
    import ikaopm_dac_deserializer_pkg::*;
#(
    parameter int MIN_BITS = 13
)
(
    input  logic             i_EMUCLK,
    input  logic             i_RST_n,
    input  logic             i_CEN_n,
    input  logic             i_SO,
    input  logic             i_SH1,
    input  logic             i_SH2,
    output logic [PCM_W-1:0] o_CH1,
    output logic [PCM_W-1:0] o_CH2,
    output logic             o_CH1_VALID,
    output logic             o_CH2_VALID,
    output logic             o_FRAME_ERR
);

    localparam logic [CNT_W-1:0] MIN_CNT = CNT_W'(MIN_BITS);

    logic [FRAME_BITS-1:0] sr_q, sr_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  sh1_q, sh1_d;
    logic                  sh2_q, sh2_d;
    logic                  synced_q, synced_d;
    logic [PCM_W-1:0]      ch1_q, ch1_d;
    logic [PCM_W-1:0]      ch2_q, ch2_d;
    logic                  ch1_valid_q, ch1_valid_d;
    logic                  ch2_valid_q, ch2_valid_d;
    logic                  frame_err_q, frame_err_d;

    logic                  cen;
    logic                  fall1;
    logic                  fall2;
    logic                  any_fall;
    logic                  long_enough;
    frame_word_t           word;
    logic [PCM_W-1:0]      pcm_word;

    assign cen         = ~i_CEN_n;
    assign fall1       = cen & sh1_q & ~i_SH1;
    assign fall2       = cen & sh2_q & ~i_SH2;
    assign any_fall    = fall1 | fall2;
    assign long_enough = (cnt_q >= MIN_CNT);

    // The closing word is the register content before this cycle's shift.
    assign word = frame_word_t'(sr_q);

    ikaopm_fp2pcm u_fp2pcm (
        .i_MANTISSA (word.mantissa),
        .i_EXPONENT (word.exponent),
        .o_PCM      (pcm_word)
    );

    // Next-state logic: shift, edge detect, bit count and frame close.
    always_comb begin
        sr_d        = sr_q;
        cnt_d       = cnt_q;
        sh1_d       = sh1_q;
        sh2_d       = sh2_q;
        synced_d    = synced_q;
        ch1_d       = ch1_q;
        ch2_d       = ch2_q;
        ch1_valid_d = 1'b0;
        ch2_valid_d = 1'b0;
        frame_err_d = 1'b0;

        if (cen) begin
            sr_d  = {i_SO, sr_q[FRAME_BITS-1:1]};
            sh1_d = i_SH1;
            sh2_d = i_SH2;

            if (any_fall) begin
                cnt_d = '0;
            end else if (cnt_q != CNT_MAX) begin
                cnt_d = cnt_q + CNT_W'(1);
            end

            // First edge after reset only establishes frame alignment.
            if (any_fall) begin
                if (!synced_q) begin
                    synced_d = 1'b1;
                end else if (long_enough) begin
                    if (fall1) begin
                        ch1_d       = pcm_word;
                        ch1_valid_d = 1'b1;
                    end
                    if (fall2) begin
                        ch2_d       = pcm_word;
                        ch2_valid_d = 1'b1;
                    end
                end else begin
                    frame_err_d = 1'b1;
                end
            end
        end
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge i_EMUCLK) begin
        if (!i_RST_n) begin
            sr_q        <= '0;
            cnt_q       <= '0;
            sh1_q       <= 1'b0;
            sh2_q       <= 1'b0;
            synced_q    <= 1'b0;
            ch1_q       <= '0;
            ch2_q       <= '0;
            ch1_valid_q <= 1'b0;
            ch2_valid_q <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            sr_q        <= sr_d;
            cnt_q       <= cnt_d;
            sh1_q       <= sh1_d;
            sh2_q       <= sh2_d;
            synced_q    <= synced_d;
            ch1_q       <= ch1_d;
            ch2_q       <= ch2_d;
            ch1_valid_q <= ch1_valid_d;
            ch2_valid_q <= ch2_valid_d;
            frame_err_q <= frame_err_d;
        end
    end

    assign o_CH1       = ch1_q;
    assign o_CH2       = ch2_q;
    assign o_CH1_VALID = ch1_valid_q;
    assign o_CH2_VALID = ch2_valid_q;
    assign o_FRAME_ERR = frame_err_q;

endmodule

// File: tb/tb_ikaopm_dac_deserializer.sv
// Bench for the OPM serial DAC receiver: directed frames plus randomized
// traffic, checked every clock against a bit-history reference model.
module tb_ikaopm_dac_deserializer;
    import ikaopm_dac_deserializer_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cen_n = 1'b1;
    logic        so = 1'b0;
    logic        sh1 = 1'b0;
    logic        sh2 = 1'b0;
    logic [15:0] ch1, ch2;
    logic        v1, v2, ferr;

    int total = 0;
    int bad   = 0;
    int cen_div = 1;

    // reference model state
    bit          hist[$];
    int          m_nbits;
    bit          m_sync, m_psh1, m_psh2;
    logic [15:0] m_ch1, m_ch2;
    bit          m_v1, m_v2, m_err;

    // observed pulse tallies
    int n_v1 = 0, n_v2 = 0, n_err = 0, n_both = 0;

    ikaopm_dac_deserializer #(.MIN_BITS(13)) dut (
        .i_EMUCLK    (clk),
        .i_RST_n     (rst_n),
        .i_CEN_n     (cen_n),
        .i_SO        (so),
        .i_SH1       (sh1),
        .i_SH2       (sh2),
        .o_CH1       (ch1),
        .o_CH2       (ch2),
        .o_CH1_VALID (v1),
        .o_CH2_VALID (v2),
        .o_FRAME_ERR (ferr)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] ref_pcm(int word);
        int mant, e, m;
        mant = word & 'h3FF;
        e    = (word >> 10) & 7;
        m    = mant ^ 'h200;
        if (m >= 512) m = m - 1024;
        if (e == 0) return 16'h0000;
        return 16'(m * (1 << (e - 1)));
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        hist.delete();
        for (int i = 0; i < 13; i++) hist.push_back(1'b0);
        m_nbits = 0;
        m_sync  = 0;
        m_psh1  = 0;
        m_psh2  = 0;
        m_ch1   = 16'h0;
        m_ch2   = 16'h0;
        m_v1    = 0;
        m_v2    = 0;
        m_err   = 0;
    endtask

    task automatic model_step();
        bit f1, f2;
        int word;
        if (!rst_n) begin
            model_reset();
            return;
        end
        m_v1  = 0;
        m_v2  = 0;
        m_err = 0;
        if (cen_n) return;
        f1 = m_psh1 && !sh1;
        f2 = m_psh2 && !sh2;
        if (f1 || f2) begin
            if (!m_sync) begin
                m_sync = 1;
            end else if (m_nbits >= 13) begin
                word = 0;
                for (int i = 0; i < 13; i++) word = word | (int'(hist[i]) << i);
                if (f1) begin m_ch1 = ref_pcm(word); m_v1 = 1; end
                if (f2) begin m_ch2 = ref_pcm(word); m_v2 = 1; end
            end else begin
                m_err = 1;
            end
            m_nbits = 0;
        end else if (m_nbits < 31) begin
            m_nbits++;
        end
        hist.push_back(so);
        void'(hist.pop_front());
        m_psh1 = sh1;
        m_psh2 = sh2;
    endtask

    // One EMUCLK: model advances on the edge, DUT is compared 1 ns later.
    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        n_v1  += int'(v1);
        n_v2  += int'(v2);
        n_err += int'(ferr);
        if (v1 && v2) n_both++;
        chk("ch1",   ch1,  m_ch1);
        chk("ch2",   ch2,  m_ch2);
        chk("v1",    v1,   m_v1);
        chk("v2",    v2,   m_v2);
        chk("ferr",  ferr, m_err);
    endtask

    task automatic cen_cycle(bit b_so, bit b_sh1, bit b_sh2);
        so  = b_so;
        sh1 = b_sh1;
        sh2 = b_sh2;
        for (int i = 0; i < cen_div; i++) begin
            cen_n = (i != 0);
            tick();
        end
    endtask

    // nbits data cycles with both strobes high, last 13 carrying word LSB
    // first, then a closing cycle that drops the selected strobes.
    task automatic send_frame(int word, int nbits, bit c1, bit c2);
        int idx;
        bit b;
        for (int i = 0; i < nbits; i++) begin
            idx = i - (nbits - 13);
            if (idx >= 0) b = bit'((word >> idx) & 1);
            else          b = bit'($urandom_range(0, 1));
            cen_cycle(b, 1'b1, 1'b1);
        end
        cen_cycle(bit'($urandom_range(0, 1)), !c1, !c2);
    endtask

    function automatic int mk(int mant, int e);
        return (e << 10) | mant;
    endfunction

    initial begin
        int s1, s2, se, sb;
        model_reset();

        // pin the reference conversion itself
        chk("pin_fn_7fc0", ref_pcm(mk('h3FF, 7)), 16'h7FC0);
        chk("pin_fn_8000", ref_pcm(mk('h000, 7)), 16'h8000);
        chk("pin_fn_0001", ref_pcm(mk('h201, 1)), 16'h0001);
        chk("pin_fn_0400", ref_pcm(mk('h280, 4)), 16'h0400);

        // reset, strobes held low
        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) begin cen_n = 1'b0; tick(); end
        rst_n = 1'b1;
        for (int i = 0; i < 100; i++) cen_cycle(bit'($urandom_range(0, 1)), 1'b0, 1'b0);
        chk("idle_ch1", ch1, 16'h0);
        chk("idle_ch2", ch2, 16'h0);
        chk("idle_pulses", n_v1 + n_v2 + n_err, 0);

        // sync on SH1, then full-scale positive frame on SH1
        cen_cycle(1'b0, 1'b1, 1'b0);
        cen_cycle(1'b0, 1'b0, 1'b0);
        chk("sync_no_pulse", n_v1 + n_v2 + n_err, 0);
        send_frame(mk('h3FF, 7), 16, 1'b1, 1'b0);
        chk("f1_ch1", ch1, 16'h7FC0);
        chk("f1_v1cnt", n_v1, 1);
        chk("f1_ch2", ch2, 16'h0);

        // channel-2 frames
        send_frame(mk('h000, 7), 16, 1'b0, 1'b1);
        chk("f2_ch2", ch2, 16'h8000);
        send_frame(mk('h201, 1), 16, 1'b0, 1'b1);
        chk("f3_ch2", ch2, 16'h0001);
        send_frame(mk('h155, 0), 16, 1'b0, 1'b1);
        chk("f4_ch2", ch2, 16'h0000);
        chk("f4_v2cnt", n_v2, 3);
        chk("f4_ch1", ch1, 16'h7FC0);

        // short frame
        s1 = n_v1; se = n_err;
        send_frame(mk('h123, 5), 10, 1'b1, 1'b0);
        chk("short_err", n_err - se, 1);
        chk("short_nov", n_v1 - s1, 0);
        chk("short_ch1", ch1, 16'h7FC0);

        // simultaneous close
        sb = n_both;
        send_frame(mk('h280, 4), 14, 1'b1, 1'b1);
        chk("both_ch1", ch1, 16'h0400);
        chk("both_ch2", ch2, 16'h0400);
        chk("both_same", n_both - sb, 1);

        // reset mid-frame with slow bit clock
        cen_div = 4;
        for (int i = 0; i < 5; i++) cen_cycle(bit'($urandom_range(0, 1)), 1'b1, 1'b1);
        rst_n = 1'b0;
        for (int i = 0; i < 8; i++) begin cen_n = ((i % 4) != 0); tick(); end
        rst_n = 1'b1;
        chk("rst_ch1", ch1, 16'h0);
        chk("rst_ch2", ch2, 16'h0);
        s1 = n_v1; s2 = n_v2; se = n_err;
        cen_cycle(1'b0, 1'b1, 1'b1);
        cen_cycle(1'b0, 1'b0, 1'b1);
        chk("resync_nov", (n_v1 - s1) + (n_v2 - s2) + (n_err - se), 0);
        for (int i = 0; i < 13; i++)
            cen_cycle(bit'((mk('h3FF, 7) >> i) & 1), 1'b1, 1'b1);
        so = 1'b0; sh1 = 1'b0; sh2 = 1'b1;
        cen_n = 1'b0;
        tick();
        chk("lat_v1_hi", v1, 1'b1);
        chk("lat_ch1", ch1, 16'h7FC0);
        cen_n = 1'b1;
        tick();
        chk("lat_v1_lo", v1, 1'b0);
        tick();
        tick();

        // randomized traffic
        for (int it = 0; it < 150; it++) begin
            int c, nb;
            cen_div = $urandom_range(1, 3);
            c  = $urandom_range(1, 3);
            nb = ($urandom_range(0, 9) == 0) ? $urandom_range(30, 40) : $urandom_range(8, 18);
            if ($urandom_range(0, 19) == 0) begin
                rst_n = 1'b0;
                cen_n = 1'b0;
                tick();
                tick();
                rst_n = 1'b1;
            end
            send_frame(int'($urandom_range(0, 8191)), nb, bit'(c & 1), bit'((c >> 1) & 1));
        end
        chk("rand_saw_valid", (n_v1 > 20) && (n_v2 > 20), 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
